pcie_mmio_cpl_gen: RTL and testbench
====================================

PCIE_MMIO_CPL_GEN -- requirements
Module: pcie_mmio_cpl_gen

Interface
REQ-001 Parameter RD_TIMEOUT, default 256: cycles to wait in RD_WAIT for rd_valid before a timeout completion is generated.
REQ-002 Parameter TAG_W, default 8: request tag width, equal to PCIE_EP_TAG_WIDTH.
REQ-003 Ports, one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  decoded MMIO read request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_tag  in  TAG_W  request tag.
- req_id  in  16  requester ID.
- req_len  in  1  0 = 1DW read, 1 = 2DW read.
- req_addr  in  7  request address bits [6:0].
- req_tc  in  3  traffic class.
- req_attr  in  3  attributes {ido, ro, ns}.
- req_vf_active  in  1  request targets a VF.
- req_ur  in  1  unsupported request; answer with UR, no register read.
- cpl_id  in  16  completer ID.
- rd_req  out  1  one-cycle read strobe to register file.
- rd_valid  in  1  register read data valid.
- rd_data  in  64  register read data.
- tx_valid, tx_sop, tx_eop  out  1 each  TX AVST control.
- tx_hdr  out  128  TLP header, DW0 in [127:96].
- tx_data  out  256  TLP payload.
- tx_vf_active  out  1  copy of captured req_vf_active.
- tx_ready  in  1  TX sink ready.
- timeout_err  out  1  one-cycle pulse on read timeout.

Function
REQ-004 FSM states IDLE, RD_WAIT, TX_SEND; req_ready = (state == IDLE), combinational from state only.
REQ-005 On req_valid && req_ready, all req_* fields are captured into holding registers.
- req_ur = 1: next state TX_SEND; no rd_req.
- req_ur = 0: rd_req pulses for the next cycle; next state RD_WAIT.
REQ-006 RD_WAIT: a wait counter starts at 0 on entry and increments each cycle.
- rd_valid = 1: capture rd_data; go to TX_SEND.
- Counter reaches RD_TIMEOUT-1 without rd_valid: load captured data with 64'hFFFF_FFFF_FFFF_FFFF; pulse timeout_err for one cycle; go to TX_SEND.
REQ-007 rd_valid and the timeout condition in the same cycle: rd_valid wins; no timeout_err pulse.
REQ-008 rd_valid outside RD_WAIT is ignored and has no state or output effect.
REQ-009 TX_SEND, single-beat TLP:
- tx_valid = tx_sop = tx_eop = 1.
- tx_hdr, tx_data and tx_vf_active held stable until tx_ready = 1.
- On tx_valid && tx_ready, go to IDLE and deassert tx_valid in the following cycle.
REQ-010 Header DW0 for CplD: fmt 3'b010, type 5'b01010, tc [22:20], attr[2] [18], attr[1:0] [13:12], length [9:0] = 1 or 2.
REQ-011 Header DW0 for UR: fmt 3'b000, type 5'b01010, length 0.
REQ-012 Header DW1: cpl_id [31:16]; status [15:13] = 3'b000 (SC) or 3'b001 (UR); byte count [11:0] = 4 (1DW or UR) or 8 (2DW).
REQ-013 Header DW2: req_id [31:16], tag zero-extended to 8 bits in [15:8], lower address [6:0] = {req_addr[6:2], 2'b00}.
REQ-014 Header DW3 (tx_hdr[31:0]) = 0.
REQ-015 tx_data placement:
- 1DW: [31:0] = data[31:0].
- 2DW: [63:0] = data[63:0].
- All other bits 0; all of tx_data is 0 for UR.
REQ-016 Timeout completions are normal SC CplD TLPs carrying all-ones data.
REQ-017 Minimum latency: rd_valid in cycle N gives tx_valid in cycle N+1. UR accepted in cycle N gives tx_valid in cycle N+1.
REQ-018 One request outstanding at a time; no new request is accepted until the current TLP handshake completes.

Reset
REQ-019 rst_n low asynchronously forces the following, including mid-operation (pending request discarded, no TLP emitted):
- State IDLE.
- Wait counter 0.
- req_ready = 1 one cycle after release.
- rd_req, timeout_err, tx_valid, tx_sop, tx_eop, tx_vf_active = 0.
- tx_hdr, tx_data = 0.

Verification
REQ-020 1DW read tag 8'h2A, addr 7'h14, rd_data 64'h0000_0000_DEAD_BEEF two cycles after rd_req -> CplD:
- length 1, byte count 4, lower address 7'h14.
- tx_data[31:0] = 32'hDEADBEEF.
REQ-021 2DW read, rd_data 64'h1122_3344_5566_7788, tx_ready low for 5 cycles -> TLP held stable for those cycles, single handshake, length 2, byte count 8.
REQ-022 req_ur = 1, tag 8'h07 -> no rd_req; Cpl with fmt 3'b000, status 3'b001, length 0, tx_valid one cycle after accept.
REQ-023 Read with no rd_valid, RD_TIMEOUT = 16 -> timeout_err pulses once; CplD data 32'hFFFF_FFFF or 64'hFFFF_FFFF_FFFF_FFFF per length.
REQ-024 rd_valid on the exact timeout cycle -> real data sent, timeout_err stays 0.
REQ-025 rst_n asserted in RD_WAIT, then late rd_valid -> no TLP emitted; req_ready = 1 after release.

Source files
------------

// File: rtl/pcie_mmio_cpl_gen.sv
// -----------------------------------------------------------------------------
// pcie_mmio_cpl_gen
//
// Turns a decoded MMIO read request into a single-beat PCIe completion TLP on
// an Avalon-ST style TX interface. One request is in flight at a time:
//
//   IDLE    : req_ready high; a request is captured on req_valid.
//   RD_WAIT : a one-cycle rd_req has been issued to the register file; wait
//             for rd_valid, or give up after RD_TIMEOUT cycles and return
//             all-ones data with a one-cycle timeout_err pulse.
//   TX_SEND : present the completion (CplD, or Cpl/UR for unsupported
//             requests) and hold it stable until tx_ready.
//
// Ports
//   clk, rst_n        : sole clock, asynchronous active-low reset
//   req_*             : decoded request (valid/ready handshake, tag, requester
//                       id, length 1DW/2DW, address [6:0], tc, attr, vf, ur)
//   cpl_id            : completer id, sampled with the request
//   rd_req            : one-cycle read strobe to the register file
//   rd_valid, rd_data : register file read response
//   tx_valid/sop/eop  : TX beat control (single-beat TLPs, all three equal)
//   tx_hdr            : 4DW TLP header, DW0 in [127:96]
//   tx_data           : TLP payload, DW0 in [31:0]
//   tx_vf_active      : req_vf_active of the request being completed
//   tx_ready          : TX sink ready
//   timeout_err       : one-cycle pulse when a read times out
// -----------------------------------------------------------------------------
module pcie_mmio_cpl_gen #(
    parameter int RD_TIMEOUT = 256,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [15:0]      req_id,
    input  logic             req_len,
    input  logic [6:0]       req_addr,
    input  logic [2:0]       req_tc,
    input  logic [2:0]       req_attr,
    input  logic             req_vf_active,
    input  logic             req_ur,
    input  logic [15:0]      cpl_id,

    output logic             rd_req,
    input  logic             rd_valid,
    input  logic [63:0]      rd_data,

    output logic             tx_valid,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic [127:0]     tx_hdr,
    output logic [255:0]     tx_data,
    output logic             tx_vf_active,
    input  logic             tx_ready,

    output logic             timeout_err
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    localparam logic [2:0] FMT_CPLD  = 3'b010;  // 3DW header with data
    localparam logic [2:0] FMT_CPL   = 3'b000;  // 3DW header, no data
    localparam logic [4:0] TYPE_CPL  = 5'b01010;
    localparam logic [2:0] STATUS_SC = 3'b000;
    localparam logic [2:0] STATUS_UR = 3'b001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        TX_SEND = 2'd2
    } state_t;

    state_t state, next_state;

    // -------------------------------------------------------------------------
    // Request holding registers
    // -------------------------------------------------------------------------
    logic [TAG_W-1:0] hold_tag;
    logic [15:0]      hold_id;
    logic             hold_len;
    logic [4:0]       hold_addr;     // address bits [6:2]; completions are DW aligned
    logic [2:0]       hold_tc;
    logic [2:0]       hold_attr;
    logic             hold_vf;
    logic             hold_ur;
    logic [15:0]      hold_cpl_id;
    logic [63:0]      rd_buf;

    logic [CNT_W-1:0] wait_cnt;

    logic             accept;
    logic             rd_hit;
    logic             rd_timeout;

    // Byte-enable bits of the address never reach the completion.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[1:0]};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its sources regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and control strobes
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        rd_hit     = 1'b0;
        rd_timeout = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = req_ur ? TX_SEND : RD_WAIT;
                end
            end

            RD_WAIT: begin
                // Data arriving on the last wait cycle still beats the timeout.
                if (rd_valid) begin
                    rd_hit     = 1'b1;
                    next_state = TX_SEND;
                end else if (wait_cnt == CNT_LAST) begin
                    rd_timeout = 1'b1;
                    next_state = TX_SEND;
                end
            end

            TX_SEND: begin
                if (tx_ready) begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign req_ready = (state == IDLE);

    // -------------------------------------------------------------------------
    // Request capture, read strobe, wait counter, read data, timeout pulse
    // -------------------------------------------------------------------------
    // NOTE: the holding registers are reset along with the control flops so
    // that tx_vf_active and the header fields are defined zero out of reset
    // and a request interrupted by reset leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_tag    <= '0;
            hold_id     <= '0;
            hold_len    <= 1'b0;
            hold_addr   <= '0;
            hold_tc     <= '0;
            hold_attr   <= '0;
            hold_vf     <= 1'b0;
            hold_ur     <= 1'b0;
            hold_cpl_id <= '0;
            rd_buf      <= '0;
            rd_req      <= 1'b0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                hold_tag    <= req_tag;
                hold_id     <= req_id;
                hold_len    <= req_len;
                hold_addr   <= req_addr[6:2];
                hold_tc     <= req_tc;
                hold_attr   <= req_attr;
                hold_vf     <= req_vf_active;
                hold_ur     <= req_ur;
                hold_cpl_id <= cpl_id;
            end

            // Strobe lands in the first RD_WAIT cycle.
            rd_req <= accept && !req_ur;

            // Counter runs only while waiting, so it is 0 on every entry.
            if (state == RD_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (rd_hit) begin
                rd_buf <= rd_data;
            end else if (rd_timeout) begin
                rd_buf <= '1;
            end

            // Pulse coincides with the first cycle of the all-ones completion.
            timeout_err <= rd_timeout;
        end
    end

    // -------------------------------------------------------------------------
    // Completion TLP assembly
    // -------------------------------------------------------------------------
    logic [31:0]  hdr_dw0;
    logic [31:0]  hdr_dw1;
    logic [31:0]  hdr_dw2;
    logic [255:0] payload;
    logic [7:0]   tag8;

    assign tag8 = 8'(hold_tag);

    always_comb begin
        hdr_dw0 = '0;
        hdr_dw1 = '0;
        hdr_dw2 = '0;
        payload = '0;

        // DW0: format/type, traffic class, attributes, length in DW
        hdr_dw0[31:29] = hold_ur ? FMT_CPL : FMT_CPLD;
        hdr_dw0[28:24] = TYPE_CPL;
        hdr_dw0[22:20] = hold_tc;
        hdr_dw0[18]    = hold_attr[2];   // ido
        hdr_dw0[13:12] = hold_attr[1:0]; // ro, ns
        if (!hold_ur) begin
            hdr_dw0[9:0] = hold_len ? 10'd2 : 10'd1;
        end

        // DW1: completer id, status, byte count (BCM stays 0)
        hdr_dw1[31:16] = hold_cpl_id;
        hdr_dw1[15:13] = hold_ur ? STATUS_UR : STATUS_SC;
        hdr_dw1[11:0]  = (!hold_ur && hold_len) ? 12'd8 : 12'd4;

        // DW2: requester id, tag, lower address (DW aligned)
        hdr_dw2[31:16] = hold_id;
        hdr_dw2[15:8]  = tag8;
        hdr_dw2[6:0]   = {hold_addr, 2'b00};

        if (!hold_ur) begin
            if (hold_len) begin
                payload[63:0] = rd_buf;
            end else begin
                payload[31:0] = rd_buf[31:0];
            end
        end
    end

    // Single-beat TLP: valid, sop and eop are the same signal. Header and
    // payload are zero outside TX_SEND and derive only from registers that are
    // frozen in TX_SEND, so they stay stable while tx_ready is low.
    assign tx_valid     = (state == TX_SEND);
    assign tx_sop       = tx_valid;
    assign tx_eop       = tx_valid;
    assign tx_hdr       = tx_valid ? {hdr_dw0, hdr_dw1, hdr_dw2, 32'h0} : '0;
    assign tx_data      = tx_valid ? payload : '0;
    assign tx_vf_active = hold_vf;

endmodule

// File: tb/tb_pcie_mmio_cpl_gen.sv
// -----------------------------------------------------------------------------
// tb_pcie_mmio_cpl_gen
//
// Drives directed and randomized MMIO read / UR transactions. For each
// transaction the bench computes, from the request fields and the chosen
// rd_valid delay and tx_ready stall, which cycles must show rd_req,
// timeout_err, a busy (not ready) DUT and a TX beat with a given header and
// payload. A single negedge compare process checks every cycle against those
// expectations. Known-good literal headers pin the expectation builder.
// -----------------------------------------------------------------------------
module tb_pcie_mmio_cpl_gen;

    localparam int T = 16;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_tag;
    logic [15:0]  req_id;
    logic         req_len;
    logic [6:0]   req_addr;
    logic [2:0]   req_tc;
    logic [2:0]   req_attr;
    logic         req_vf_active;
    logic         req_ur;
    logic [15:0]  cpl_id;
    logic         rd_req;
    logic         rd_valid;
    logic [63:0]  rd_data;
    logic         tx_valid;
    logic         tx_sop;
    logic         tx_eop;
    logic [127:0] tx_hdr;
    logic [255:0] tx_data;
    logic         tx_vf_active;
    logic         tx_ready;
    logic         timeout_err;

    pcie_mmio_cpl_gen #(
        .RD_TIMEOUT (T),
        .TAG_W      (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_tag       (req_tag),
        .req_id        (req_id),
        .req_len       (req_len),
        .req_addr      (req_addr),
        .req_tc        (req_tc),
        .req_attr      (req_attr),
        .req_vf_active (req_vf_active),
        .req_ur        (req_ur),
        .cpl_id        (cpl_id),
        .rd_req        (rd_req),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .tx_valid      (tx_valid),
        .tx_sop        (tx_sop),
        .tx_eop        (tx_eop),
        .tx_hdr        (tx_hdr),
        .tx_data       (tx_data),
        .tx_vf_active  (tx_vf_active),
        .tx_ready      (tx_ready),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_on   = 1'b0;

    // Expectations keyed by cycle number
    bit           exp_rdreq [int];
    bit           exp_to    [int];
    bit           exp_busy  [int];
    logic [127:0] exp_hdr   [int];
    logic [255:0] exp_dat   [int];
    bit           exp_vf    [int];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Completion header from the request fields, by plain arithmetic
    function automatic logic [127:0] model_hdr(input bit ur, input bit len,
                                               input logic [2:0] tc, input logic [2:0] attr,
                                               input logic [7:0] tag, input logic [15:0] rid,
                                               input logic [6:0] addr, input logic [15:0] cid);
        int unsigned u_tc, u_attr, u_tag, u_rid, u_addr, u_cid;
        int unsigned fmt, ndw, bc, st;
        int unsigned dw0, dw1, dw2;
        u_tc   = tc;
        u_attr = attr;
        u_tag  = tag;
        u_rid  = rid;
        u_addr = addr;
        u_cid  = cid;
        fmt = ur ? 0 : 2;
        ndw = ur ? 0 : (len ? 2 : 1);
        bc  = (!ur && len) ? 8 : 4;
        st  = ur ? 1 : 0;
        dw0 = (fmt << 29) + (32'd10 << 24) + (u_tc << 20)
            + ((u_attr / 4) << 18) + ((u_attr % 4) << 12) + ndw;
        dw1 = (u_cid << 16) + (st << 13) + bc;
        dw2 = (u_rid << 16) + (u_tag << 8) + (u_addr / 4) * 4;
        return {dw0, dw1, dw2, 32'h0};
    endfunction

    function automatic logic [255:0] model_data(input bit ur, input bit len, input logic [63:0] d);
        if (ur) return '0;
        if (len) return {192'b0, d};
        return {224'b0, d[31:0]};
    endfunction

    // One compare process for every clocked output, every cycle
    always @(negedge clk) begin
        if (cmp_on) begin
            check("rd_req", {255'b0, rd_req}, {255'b0, exp_rdreq.exists(cyc) != 0});
            check("timeout_err", {255'b0, timeout_err}, {255'b0, exp_to.exists(cyc) != 0});
            check("req_ready", {255'b0, req_ready}, {255'b0, exp_busy.exists(cyc) == 0});
            check("tx_valid", {255'b0, tx_valid}, {255'b0, exp_hdr.exists(cyc) != 0});
            if (exp_hdr.exists(cyc)) begin
                check("tx_sop", {255'b0, tx_sop}, 256'd1);
                check("tx_eop", {255'b0, tx_eop}, 256'd1);
                check("tx_hdr", {128'b0, tx_hdr}, {128'b0, exp_hdr[cyc]});
                check("tx_data", tx_data, exp_dat[cyc]);
                check("tx_vf_active", {255'b0, tx_vf_active}, {255'b0, exp_vf[cyc]});
            end
        end
    end

    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            rd_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            rd_data   = {$urandom, $urandom};
            tx_ready  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // Runs one transaction starting in the current cycle (DUT idle).
    // d: cycles from rd_req to rd_valid (d >= T means no response in time).
    // stall: cycles tx_ready stays low once the TLP is presented.
    task automatic run_txn(input bit ur, input bit len, input int d, input int stall,
                           input logic [7:0] tag, input logic [15:0] rid,
                           input logic [6:0] addr, input logic [2:0] tc,
                           input logic [2:0] attr, input bit vf,
                           input logic [15:0] cid, input logic [63:0] data,
                           input bit pin_en, input logic [127:0] pin_hdr,
                           input logic [255:0] pin_dat, input bit noise);
        int a, s, e;
        bit tmo;
        bit in_wait;
        logic [63:0] eff;
        a   = cyc;
        tmo = !ur && (d >= T);
        if (ur)       s = a + 1;
        else if (tmo) s = a + 1 + T;
        else          s = a + 2 + d;
        e   = s + stall;
        eff = tmo ? 64'hFFFF_FFFF_FFFF_FFFF : data;

        if (!ur) exp_rdreq[a + 1] = 1'b1;
        if (tmo) exp_to[s] = 1'b1;
        for (int c = a + 1; c <= e; c++) exp_busy[c] = 1'b1;
        for (int c = s; c <= e; c++) begin
            exp_hdr[c] = model_hdr(ur, len, tc, attr, tag, rid, addr, cid);
            exp_dat[c] = model_data(ur, len, eff);
            exp_vf[c]  = vf;
        end

        for (int c = a; c <= e; c++) begin
            if (c == a) begin
                req_valid     = 1'b1;
                req_ur        = ur;
                req_len       = len;
                req_tag       = tag;
                req_id        = rid;
                req_addr      = addr;
                req_tc        = tc;
                req_attr      = attr;
                req_vf_active = vf;
                cpl_id        = cid;
            end else begin
                // Requests offered while busy must be ignored.
                req_valid     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                req_ur        = 1'($urandom_range(0, 1));
                req_len       = 1'($urandom_range(0, 1));
                req_tag       = 8'($urandom);
                req_id        = 16'($urandom);
                req_addr      = 7'($urandom);
                req_tc        = 3'($urandom);
                req_attr      = 3'($urandom);
                req_vf_active = 1'($urandom_range(0, 1));
                cpl_id        = 16'($urandom);
            end
            in_wait = !ur && (c > a) && (c < s);
            if (in_wait) rd_valid = !tmo && (c == a + 1 + d);
            else         rd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            rd_data  = (in_wait && rd_valid) ? data : {$urandom, $urandom};
            tx_ready = (c < s) ? (noise ? 1'($urandom_range(0, 1)) : 1'b0) : (c >= e);
            if (pin_en && c == s) begin
                check("pin_hdr", {128'b0, tx_hdr}, {128'b0, pin_hdr});
                check("pin_data", tx_data, pin_dat);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rd_valid  = 1'b0;
        tx_ready  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        rst_n         = 1'b0;
        req_valid     = 1'b1;   // ignored while in reset
        req_tag       = '0;
        req_id        = '0;
        req_len       = 1'b0;
        req_addr      = '0;
        req_tc        = '0;
        req_attr      = '0;
        req_vf_active = 1'b1;
        req_ur        = 1'b0;
        cpl_id        = '0;
        rd_valid      = 1'b1;
        rd_data       = '1;
        tx_ready      = 1'b0;

        #12;
        check("rst_req_ready", {255'b0, req_ready}, 256'd1);
        check("rst_rd_req", {255'b0, rd_req}, 256'd0);
        check("rst_timeout_err", {255'b0, timeout_err}, 256'd0);
        check("rst_tx_valid", {255'b0, tx_valid}, 256'd0);
        check("rst_tx_sop_eop", {254'b0, tx_sop, tx_eop}, 256'd0);
        check("rst_tx_vf", {255'b0, tx_vf_active}, 256'd0);
        check("rst_tx_hdr", {128'b0, tx_hdr}, 256'd0);
        check("rst_tx_data", tx_data, 256'd0);

        req_valid     = 1'b0;
        rd_valid      = 1'b0;
        req_vf_active = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("req_ready_after_rst", {255'b0, req_ready}, 256'd1);
        cmp_on = 1'b1;

        // 1DW read, data two cycles after rd_req
        run_txn(1'b0, 1'b0, 2, 0, 8'h2A, 16'h0100, 7'h14, 3'd0, 3'd0, 1'b0, 16'h0200,
                64'h0000_0000_DEAD_BEEF, 1'b1,
                128'h4A000001_02000004_01002A14_00000000, 256'hDEADBEEF, 1'b0);
        idle(2, 1'b1);

        // 2DW read, sink stalls 5 cycles
        run_txn(1'b0, 1'b1, 1, 5, 8'h11, 16'hBEEF, 7'h7F, 3'b101, 3'b111, 1'b1, 16'h0200,
                64'h1122_3344_5566_7788, 1'b1,
                128'h4A543002_02000008_BEEF117C_00000000, 256'h11223344_55667788, 1'b1);
        idle(1, 1'b1);

        // Unsupported request
        run_txn(1'b1, 1'b0, 0, 0, 8'h07, 16'h1234, 7'h08, 3'd0, 3'd0, 1'b0, 16'h0200,
                64'h0, 1'b1,
                128'h0A000000_02002004_12340708_00000000, 256'h0, 1'b1);

        // Timeout, 1DW then 2DW
        run_txn(1'b0, 1'b0, T, 1, 8'h33, 16'h0001, 7'h20, 3'd0, 3'd0, 1'b0, 16'h0200,
                64'h0123_4567_89AB_CDEF, 1'b1,
                128'h4A000001_02000004_00013320_00000000, 256'hFFFFFFFF, 1'b1);
        run_txn(1'b0, 1'b1, T + 2, 0, 8'h44, 16'h0002, 7'h00, 3'd0, 3'd0, 1'b1, 16'h0200,
                64'h0123_4567_89AB_CDEF, 1'b1,
                128'h4A000002_02000008_00024400_00000000, 256'hFFFFFFFF_FFFFFFFF, 1'b1);

        // rd_valid on the exact timeout cycle
        run_txn(1'b0, 1'b0, T - 1, 0, 8'h55, 16'h0003, 7'h0C, 3'd0, 3'd0, 1'b0, 16'h0200,
                64'hCAFE_F00D_1234_5678, 1'b1,
                128'h4A000001_02000004_0003550C_00000000, 256'h12345678, 1'b1);

        // Minimum latency: rd_valid in the rd_req cycle, then back-to-back UR
        run_txn(1'b0, 1'b1, 0, 0, 8'h66, 16'h4321, 7'h33, 3'd2, 3'd5, 1'b1, 16'h0BAD,
                64'hA5A5_5A5A_0F0F_F0F0, 1'b0, '0, '0, 1'b1);
        run_txn(1'b1, 1'b1, 0, 2, 8'h77, 16'h8765, 7'h41, 3'd7, 3'd1, 1'b1, 16'h0BAD,
                64'h0, 1'b0, '0, '0, 1'b1);
        idle(2, 1'b1);

        // Reset while waiting for read data; late rd_valid must produce nothing
        a = cyc;
        exp_rdreq[a + 1] = 1'b1;
        exp_busy[a + 1]  = 1'b1;
        exp_busy[a + 2]  = 1'b1;
        req_valid     = 1'b1;
        req_ur        = 1'b0;
        req_len       = 1'b1;
        req_tag       = 8'h99;
        req_id        = 16'h0099;
        req_addr      = 7'h10;
        req_tc        = 3'd1;
        req_attr      = 3'd1;
        req_vf_active = 1'b1;
        cpl_id        = 16'h0200;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req_ready", {255'b0, req_ready}, 256'd1);
        check("midrst_tx_valid", {255'b0, tx_valid}, 256'd0);
        check("midrst_rd_req", {255'b0, rd_req}, 256'd0);
        check("midrst_tx_vf", {255'b0, tx_vf_active}, 256'd0);
        check("midrst_tx_hdr", {128'b0, tx_hdr}, 256'd0);
        check("midrst_tx_data", tx_data, 256'd0);
        @(posedge clk); #3;
        rst_n    = 1'b1;
        rd_valid = 1'b1;
        rd_data  = 64'h1234_5678_9ABC_DEF0;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        check("post_rst_req_ready", {255'b0, req_ready}, 256'd1);
        idle(3, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit ur;
            ur = ($urandom_range(0, 4) == 0);
            run_txn(ur, 1'($urandom_range(0, 1)), int'($urandom_range(0, T + 3)),
                    int'($urandom_range(0, 4)), 8'($urandom), 16'($urandom), 7'($urandom),
                    3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                    {$urandom, $urandom}, 1'b0, '0, '0, 1'b1);
            idle(int'($urandom_range(0, 2)), 1'b1);
        end

        idle(3, 1'b0);
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
